// File: rtl/bus_arb_pkg.sv
// Shared types and width helpers for the round-robin bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Index width for NUM_REQ channels; a single channel still needs one bit.
    function automatic int idx_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Beat counter width for MAX_BEATS beats per tenure.
    function automatic int cnt_w(input int max_beats);
        return $clog2(max_beats) + 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin picker: first set req bit at or after ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; ports are req/ptr in, found/winner out.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic [idx_w(NUM_REQ)-1:0]   ptr,
    output logic                        found,
    output logic [idx_w(NUM_REQ)-1:0]   winner
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     offs;
    logic [IDX_W:0]       sum;

    always_comb begin
        // Two copies back to back so a window starting at ptr wraps for free.
        dbl   = {req, req};
        rot   = dbl[ptr +: NUM_REQ];
        found = 1'b0;
        offs  = '0;
        // Descending scan so the lowest set bit of the window wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                offs  = IDX_W'(i);
            end
        end
        // ptr + offs is below 2*NUM_REQ, so one conditional subtract is a full modulo.
        sum = {1'b0, ptr} + {1'b0, offs};
        if (sum >= N_EXT) begin
            sum = sum - N_EXT;
        end
        winner = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter of NUM_REQ requesters onto one start/ready beat bus, max MAX_BEATS beats per tenure.
// Latency: req at cycle k -> registered gnt at k+1; bus fields mux combinationally from the owner.
// Backpressure: bus_ready low stalls the beat count; the owner holds its fields while stalled.
// Ports: clk/rst (sync, active high); req/req_addr/req_data/req_mode per channel (packed);
//        gnt one-hot, bus_start/addr/data/mode toward target, bus_ready from target, busy, owner index.
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MODE_W    = 2,
    parameter int MAX_BEATS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ*MODE_W-1:0]   req_mode,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        bus_start,
    output logic [ADDR_W-1:0]           bus_addr,
    output logic [DATA_W-1:0]           bus_data,
    output logic [MODE_W-1:0]           bus_mode,
    input  logic                        bus_ready,
    output logic                        busy,
    output logic [idx_w(NUM_REQ)-1:0]   owner
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam int CNT_W = cnt_w(MAX_BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

    arb_state_t          state, state_n;
    logic [NUM_REQ-1:0]  gnt_n;
    logic [IDX_W-1:0]    ptr, ptr_n;
    logic [IDX_W-1:0]    owner_n;
    logic [CNT_W-1:0]    beat_cnt, cnt_n;

    logic                found;
    logic [IDX_W-1:0]    winner;
    logic                beat_acc;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .found  (found),
        .winner (winner)
    );

    // Output mux: everything toward the target is zero outside a tenure.
    always_comb begin
        busy      = (state == BUSY);
        bus_start = 1'b0;
        bus_addr  = '0;
        bus_data  = '0;
        bus_mode  = '0;
        if (state == BUSY) begin
            bus_start = req[owner];
            bus_addr  = req_addr[owner*ADDR_W +: ADDR_W];
            bus_data  = req_data[owner*DATA_W +: DATA_W];
            bus_mode  = req_mode[owner*MODE_W +: MODE_W];
        end
    end

    assign beat_acc = bus_start && bus_ready;

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        ptr_n   = ptr;
        owner_n = owner;
        cnt_n   = beat_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = BUSY;
                    gnt_n   = NUM_REQ'(1) << winner;
                    owner_n = winner;
                    cnt_n   = '0;
                end
            end
            BUSY: begin
                // Release when the owner walks away or its final allowed beat lands.
                // The pointer only moves here, one past the departing owner.
                if (!req[owner] || (beat_acc && (beat_cnt == LAST_CNT))) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    ptr_n   = (owner == LAST_IDX) ? '0 : owner + 1'b1;
                    cnt_n   = '0;
                end else if (beat_acc) begin
                    cnt_n = beat_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            ptr      <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            beat_cnt <= cnt_n;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: three instances (4ch/4 beats, 4ch/2 beats, 3ch/4 beats).
// Stimulus pushes expected grants, beats and tenure lengths; one monitor pops and compares.
// Point probes of idle/stall state are handed to the same monitor.
module tb_bus_arbiter_rr;

    typedef struct {
        logic [3:0] gnt;
        int         owner;
        int         gap;
    } grant_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic [1:0] mode;
    } beat_t;

    typedef struct {
        int         dut;
        logic [3:0] gnt;
        logic       busy;
        logic       start;
        logic [7:0] addr;
        int         cnt;
        int         ptr;
    } probe_t;

    logic        clk;
    logic        rst;
    logic        ready;
    logic [3:0]  req0, req1;
    logic [2:0]  req2;
    logic [31:0] raddr, rdata;
    logic [7:0]  rmode;

    logic [3:0] gnt0, gnt1;
    logic [2:0] gnt2;
    logic       start0, start1, start2;
    logic [7:0] addr0, addr1, addr2, data0, data1, data2;
    logic [1:0] mode0, mode1, mode2;
    logic       busy0, busy1, busy2;
    logic [1:0] owner0, owner1, owner2;

    bus_arbiter_rr #(.NUM_REQ(4), .MAX_BEATS(4)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .req_addr(raddr), .req_data(rdata), .req_mode(rmode),
        .gnt(gnt0), .bus_start(start0), .bus_addr(addr0), .bus_data(data0), .bus_mode(mode0),
        .bus_ready(ready), .busy(busy0), .owner(owner0));

    bus_arbiter_rr #(.NUM_REQ(4), .MAX_BEATS(2)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .req_addr(raddr), .req_data(rdata), .req_mode(rmode),
        .gnt(gnt1), .bus_start(start1), .bus_addr(addr1), .bus_data(data1), .bus_mode(mode1),
        .bus_ready(ready), .busy(busy1), .owner(owner1));

    bus_arbiter_rr #(.NUM_REQ(3), .MAX_BEATS(4)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .req_addr(raddr[23:0]), .req_data(rdata[23:0]),
        .req_mode(rmode[5:0]), .gnt(gnt2), .bus_start(start2), .bus_addr(addr2), .bus_data(data2),
        .bus_mode(mode2), .bus_ready(ready), .busy(busy2), .owner(owner2));

    logic [3:0] m_gnt   [3];
    logic       m_start [3];
    logic       m_busy  [3];
    logic [7:0] m_addr  [3];
    logic [7:0] m_data  [3];
    logic [1:0] m_mode  [3];
    int         m_owner [3];
    int         m_cnt   [3];
    int         m_ptr   [3];

    assign m_gnt[0] = gnt0;           assign m_gnt[1] = gnt1;           assign m_gnt[2] = {1'b0, gnt2};
    assign m_start[0] = start0;       assign m_start[1] = start1;       assign m_start[2] = start2;
    assign m_busy[0] = busy0;         assign m_busy[1] = busy1;         assign m_busy[2] = busy2;
    assign m_addr[0] = addr0;         assign m_addr[1] = addr1;         assign m_addr[2] = addr2;
    assign m_data[0] = data0;         assign m_data[1] = data1;         assign m_data[2] = data2;
    assign m_mode[0] = mode0;         assign m_mode[1] = mode1;         assign m_mode[2] = mode2;
    assign m_owner[0] = int'(owner0); assign m_owner[1] = int'(owner1); assign m_owner[2] = int'(owner2);
    assign m_cnt[0] = int'(dut0.beat_cnt);
    assign m_cnt[1] = int'(dut1.beat_cnt);
    assign m_cnt[2] = int'(dut2.beat_cnt);
    assign m_ptr[0] = int'(dut0.ptr);
    assign m_ptr[1] = int'(dut1.ptr);
    assign m_ptr[2] = int'(dut2.ptr);

    grant_t exp_gnt  [3][$];
    beat_t  exp_beat [3][$];
    int     exp_len  [3][$];

    probe_t pr;
    int     probe_seq;
    logic   done;

    int compared;
    int mismatched;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel fields are fixed per channel so every beat identifies its source.
    function automatic beat_t mk_beat(input int ch);
        beat_t b;
        b.addr = 8'hA3 + 8'(ch);
        b.data = 8'h11 * 8'(ch + 1);
        b.mode = 2'(ch);
        return b;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_tenure(input int d, input int ch, input int nbeats, input int gap);
        grant_t     g;
        logic [3:0] one;
        one     = 4'b0001;
        g.gnt   = one << ch;
        g.owner = ch;
        g.gap   = gap;
        exp_gnt[d].push_back(g);
        for (int i = 0; i < nbeats; i++) exp_beat[d].push_back(mk_beat(ch));
        exp_len[d].push_back(nbeats);
    endtask

    task automatic probe(input int d, input logic [3:0] g, input logic b, input logic s,
                         input logic [7:0] a, input int c, input int p);
        pr.dut   = d;
        pr.gnt   = g;
        pr.busy  = b;
        pr.start = s;
        pr.addr  = a;
        pr.cnt   = c;
        pr.ptr   = p;
        probe_seq = probe_seq + 1;
    endtask

    // Stimulus: timing is counted in posedges; inputs change 1 time unit after an edge.
    initial begin
        rst = 1'b1; ready = 1'b1; done = 1'b0; probe_seq = 0;
        req0 = '0; req1 = '0; req2 = '0;
        for (int i = 0; i < 4; i++) begin
            raddr[i*8 +: 8] = 8'hA3 + 8'(i);
            rdata[i*8 +: 8] = 8'h11 * 8'(i + 1);
            rmode[i*2 +: 2] = 2'(i);
        end
        tick(3);
        rst = 1'b0;
        probe(0, 4'b0000, 1'b0, 1'b0, 8'h00, 0, 0);
        tick(1); probe(1, 4'b0000, 1'b0, 1'b0, 8'h00, 0, 0);
        tick(1); probe(2, 4'b0000, 1'b0, 1'b0, 8'h00, 0, 0);
        tick(1);

        // Lone requester ch2: 4 beats, one idle cycle, regrant.
        exp_tenure(0, 2, 4, -1);
        exp_tenure(0, 2, 4, 1);
        req0 = 4'b0100;
        tick(5); probe(0, 4'b0000, 1'b0, 1'b0, 8'h00, 0, 3);
        tick(5); req0 = 4'b0000;
        tick(2);

        // ch1 walks away after 2 beats; ch2 (raised meanwhile) wins next; then a 3-cycle stall.
        exp_tenure(0, 1, 2, -1);
        exp_tenure(0, 2, 4, 1);
        req0 = 4'b0010;
        tick(3); req0 = 4'b0100; probe(0, 4'b0010, 1'b1, 1'b0, 8'hA4, 2, 3);
        tick(3); ready = 1'b0;   probe(0, 4'b0100, 1'b1, 1'b1, 8'hA5, 1, 2);
        tick(1);                 probe(0, 4'b0100, 1'b1, 1'b1, 8'hA5, 1, 2);
        tick(1);                 probe(0, 4'b0100, 1'b1, 1'b1, 8'hA5, 1, 2);
        tick(1); ready = 1'b1;
        tick(3); req0 = 4'b0000;
        tick(2);

        // Reset during beat 2 of a ch3 burst; ch0 then ch3 follow.
        exp_tenure(0, 3, 2, -1);
        exp_tenure(0, 0, 4, 1);
        exp_tenure(0, 3, 4, 1);
        req0 = 4'b1000;
        tick(2); rst = 1'b1;
        tick(1); rst = 1'b0; req0 = 4'b1001; probe(0, 4'b0000, 1'b0, 1'b0, 8'h00, 0, 0);
        tick(10); req0 = 4'b0000;
        tick(2);

        // MAX_BEATS=2, all channels requesting: order 0,1,2,3,0.
        exp_tenure(1, 0, 2, -1);
        exp_tenure(1, 1, 2, 1);
        exp_tenure(1, 2, 2, 1);
        exp_tenure(1, 3, 2, 1);
        exp_tenure(1, 0, 2, 1);
        req1 = 4'b1111;
        tick(15); req1 = 4'b0000;
        tick(2);

        // Three channels: ch2 release wraps ptr to 0; ch0 wins, drops at once (no beats).
        exp_tenure(2, 2, 4, -1);
        exp_tenure(2, 0, 0, 1);
        req2 = 3'b100;
        tick(5); req2 = 3'b111; probe(2, 4'b0000, 1'b0, 1'b0, 8'h00, 0, 0);
        tick(1); req2 = 3'b000;
        tick(1); probe(2, 4'b0000, 1'b0, 1'b0, 8'h00, 0, 1);
        tick(3);
        done = 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        compared = compared + 1;
        if (act != exp) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    initial begin
        logic [3:0] prev_gnt [3];
        int         gap_cnt  [3];
        int         ten_beats[3];
        int         probe_seen;
        grant_t     g;
        beat_t      b;
        int         len;
        compared   = 0;
        mismatched = 0;
        probe_seen = 0;
        for (int d = 0; d < 3; d++) begin
            prev_gnt[d]  = '0;
            gap_cnt[d]   = 1000;
            ten_beats[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (m_gnt[d] != 4'b0000 && prev_gnt[d] == 4'b0000) begin
                    if (exp_gnt[d].size() == 0) begin
                        chk($sformatf("d%0d unexpected grant", d), int'(m_gnt[d]), 0);
                    end else begin
                        g = exp_gnt[d].pop_front();
                        chk($sformatf("d%0d gnt", d), int'(m_gnt[d]), int'(g.gnt));
                        chk($sformatf("d%0d owner", d), m_owner[d], g.owner);
                        if (g.gap >= 0) chk($sformatf("d%0d idle gap", d), gap_cnt[d], g.gap);
                    end
                    gap_cnt[d]   = 0;
                    ten_beats[d] = 0;
                end else if (m_gnt[d] == 4'b0000) begin
                    gap_cnt[d] = gap_cnt[d] + 1;
                end
                if (m_gnt[d] == 4'b0000 && prev_gnt[d] != 4'b0000) begin
                    if (exp_len[d].size() == 0) begin
                        chk($sformatf("d%0d unexpected release", d), ten_beats[d], -1);
                    end else begin
                        len = exp_len[d].pop_front();
                        chk($sformatf("d%0d tenure beats", d), ten_beats[d], len);
                    end
                end
                if (m_gnt[d] != 4'b0000 && m_start[d] && ready) begin
                    ten_beats[d] = ten_beats[d] + 1;
                    if (exp_beat[d].size() == 0) begin
                        chk($sformatf("d%0d unexpected beat", d), int'(m_addr[d]), -1);
                    end else begin
                        b = exp_beat[d].pop_front();
                        chk($sformatf("d%0d beat addr", d), int'(m_addr[d]), int'(b.addr));
                        chk($sformatf("d%0d beat data", d), int'(m_data[d]), int'(b.data));
                        chk($sformatf("d%0d beat mode", d), int'(m_mode[d]), int'(b.mode));
                    end
                end
                prev_gnt[d] = m_gnt[d];
            end
            if (probe_seq != probe_seen) begin
                probe_seen = probe_seq;
                chk($sformatf("probe%0d d%0d gnt", probe_seen, pr.dut), int'(m_gnt[pr.dut]), int'(pr.gnt));
                chk($sformatf("probe%0d d%0d busy", probe_seen, pr.dut), int'(m_busy[pr.dut]), int'(pr.busy));
                chk($sformatf("probe%0d d%0d bus_start", probe_seen, pr.dut), int'(m_start[pr.dut]), int'(pr.start));
                chk($sformatf("probe%0d d%0d bus_addr", probe_seen, pr.dut), int'(m_addr[pr.dut]), int'(pr.addr));
                if (pr.cnt >= 0) chk($sformatf("probe%0d d%0d beat_cnt", probe_seen, pr.dut), m_cnt[pr.dut], pr.cnt);
                if (pr.ptr >= 0) chk($sformatf("probe%0d d%0d ptr", probe_seen, pr.dut), m_ptr[pr.dut], pr.ptr);
            end
            if (done) begin
                for (int d = 0; d < 3; d++) begin
                    chk($sformatf("d%0d grants left over", d), exp_gnt[d].size(), 0);
                    chk($sformatf("d%0d beats left over", d), exp_beat[d].size(), 0);
                    chk($sformatf("d%0d releases left over", d), exp_len[d].size(), 0);
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
                $finish;
            end
        end
    end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Parametrised N-channel successor to the single-master req/gnt bus handshake.
- Arbitrates NUM_REQ requesters onto one shared downstream bus using round-robin priority.
- Muxes the winner's addr/data/mode onto the bus and runs a start/ready beat handshake.
- Caps each tenure at MAX_BEATS accepted beats so no requester can lock the bus; sits between requester modules and a shared memory/peripheral target.

Parameters:
- NUM_REQ, 4, number of requesting channels (≥1).
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- MODE_W, 2, mode field width.
- MAX_BEATS, 4, maximum accepted beats per grant tenure (≥1).

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-channel request; held high while the channel wants the bus.
- req_addr  input  NUM_REQ*ADDR_W  per-channel address, packed, channel i at [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  per-channel write data, packed likewise.
- req_mode  input  NUM_REQ*MODE_W  per-channel mode, packed likewise.
- gnt  output  NUM_REQ  one-hot grant (or all zero), registered.
- bus_start  output  1  beat valid toward the target.
- bus_addr  output  ADDR_W  winner's address.
- bus_data  output  DATA_W  winner's data.
- bus_mode  output  MODE_W  winner's mode.
- bus_ready  input  1  target accepts the beat this cycle.
- busy  output  1  arbiter is in BUSY.
- owner  output  $clog2(NUM_REQ) (min 1)  index of the current/last winner.

Behaviour:
- Reset: state=IDLE, gnt=0, ptr=0, owner=0, beat_cnt=0, busy=0, bus_start=0, bus_addr/data/mode=0.
- Reset overrides everything; asserted mid-burst, gnt drops at that edge.
- FSM has two states: IDLE and BUSY.
- IDLE → BUSY:
  - Condition: |req at a posedge.
  - Winner: first set req bit searching ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - On the edge: gnt=onehot(winner), owner=winner, beat_cnt=0.
  - Latency: req high at cycle k gives gnt high in cycle k+1.
- BUSY outputs:
  - bus_start = req[owner].
  - bus_addr/data/mode = channel owner's fields when in BUSY, else 0.
  - busy=1.
- Beat accepted = bus_start && bus_ready.
- bus_ready low: beat_cnt holds; outputs track the owner's inputs (the requester must hold them stable).
- BUSY → IDLE, evaluated each BUSY cycle:
  - (a) req[owner]==0: release immediately; no beat that cycle.
  - (b) beat accepted and beat_cnt==MAX_BEATS-1: release after the final beat.
  - On release: gnt=0, ptr=(owner+1) mod NUM_REQ, beat_cnt=0.
  - Otherwise, an accepted beat increments beat_cnt.
- Turnaround: exactly one IDLE cycle with gnt=0 between tenures, even when the same channel is still requesting.
- Fairness:
  - Ptr advance guarantees every continuously requesting channel is granted within NUM_REQ tenures.
  - Ptr updates only on release.
- Requests for non-owner channels arriving during BUSY are ignored until the next IDLE.
- MAX_BEATS=1: release after every accepted beat.
- NUM_REQ=1: ptr stays 0.
- beat_cnt width is $clog2(MAX_BEATS)+1; never exceeds MAX_BEATS-1.

Decomposition:
- Package bus_arb_pkg:
  - state enum (IDLE, BUSY).
  - width helper constants/functions (IDX_W from NUM_REQ, CNT_W from MAX_BEATS).
- Sub-module rr_pick:
  - Purely combinational; inputs req vector and ptr.
  - Outputs found flag and winner index; implemented by double-width rotate and priority encode.
- Top bus_arbiter_rr holds the FSM, counters, registered gnt and the output mux.

Test Plan:
- Lone requester, NUM_REQ=4, MAX_BEATS=4, bus_ready=1: req=4'b0100 from cycle 0 → gnt=4'b0100 in cycles 1–4 with 4 beats; gnt=0 in cycle 5; regrant in cycle 6; ptr=3 after the first release.
- All four requesting, MAX_BEATS=2, ready=1: grant order 0,1,2,3,0; each tenure exactly 2 beats; one idle cycle between tenures.
- Owner ch1 drops req after 2 accepted beats (MAX_BEATS=4): bus_start falls with req; gnt=0 next edge; next grant goes to ch2 when ch2 requests.
- bus_ready held low 3 cycles mid-burst: beat_cnt unchanged; bus_start=1 and bus_addr=req_addr[ch] (e.g. 8'hA5) stable; burst completes with exactly MAX_BEATS accepted beats.
- rst pulsed for 1 cycle during beat 2 of a ch3 burst: next cycle gnt=0, busy=0, ptr=0; with req=4'b1001, the next grant is ch0.
- NUM_REQ=3, ch2 wins then releases: ptr wraps to 0; with req=3'b111, ch0 is granted next.
